// File: rtl/irq_vector_unit.sv
// irq_vector_unit: prioritised interrupt vector source for the SAP-2 MPU address path.
//
// Captures rising edges on iIrq into sticky pending bits, requests service from the
// controller, and on acknowledge latches the lowest-index eligible channel. The channel's
// two-byte vector address (low byte at VEC_TOP-2k-1, high byte at VEC_TOP-2k) is then
// presented on the tristate MAR bus, paced by iNext. The serviced pending bit is cleared
// when the high byte is consumed.
//
// Ports:
//   iClk      system clock, rising edge
//   iRst      asynchronous active-high reset
//   iIrq      interrupt request lines (rising-edge sensitive)
//   iMask     1 = channel masked
//   iIntEn    global interrupt enable
//   iClrPend  per-channel software clear strobe
//   iAck      controller accepts the interrupt
//   iNext     controller advance strobe for the vector byte sequence
//   iEn       MAR bus output enable
//   oIntReq   interrupt request to controller
//   oChan     latched channel being serviced
//   oPend     pending bit vector
//   oHiByte   high-byte address is being presented
//   oDone     one-cycle pulse after the vector fetch completes
//   oMAR      vector address onto MAR bus, Z when not driving

module irq_vector_unit #(
  parameter int unsigned       ADDR_W  = 16,
  parameter int unsigned       NUM_CH  = 4,
  parameter logic [ADDR_W-1:0] VEC_TOP = 16'hFFFF,
  parameter int unsigned       CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [NUM_CH-1:0] iIrq,
  input  logic [NUM_CH-1:0] iMask,
  input  logic              iIntEn,
  input  logic [NUM_CH-1:0] iClrPend,
  input  logic              iAck,
  input  logic              iNext,
  input  logic              iEn,
  output logic              oIntReq,
  output logic [CH_W-1:0]   oChan,
  output logic [NUM_CH-1:0] oPend,
  output logic              oHiByte,
  output logic              oDone,
  output tri   [ADDR_W-1:0] oMAR
);

  typedef enum logic [1:0] {StIdle, StReq, StLo, StHi} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   irq_q;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic                done_q, done_d;

  logic [NUM_CH-1:0]   rise;
  logic [NUM_CH-1:0]   elig;
  logic [NUM_CH-1:0]   svc_clr;
  logic [CH_W-1:0]     winner;
  logic [ADDR_W-1:0]   chan_x2;
  logic [ADDR_W-1:0]   vec_addr;
  logic                drive;

  assign rise = iIrq & ~irq_q;
  assign elig = pend_q & ~iMask;

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    winner = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (elig[i]) winner = CH_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    done_d  = 1'b0;
    svc_clr = '0;
    unique case (state_q)
      StIdle: begin
        if (iIntEn && (elig != '0)) state_d = StReq;
      end
      StReq: begin
        // Acknowledge beats withdrawal in the same cycle.
        if (iAck) begin
          chan_d  = winner;
          state_d = StLo;
        end else if (!iIntEn || (elig == '0)) begin
          state_d = StIdle;
        end
      end
      StLo: begin
        if (iNext) state_d = StHi;
      end
      StHi: begin
        if (iNext) begin
          state_d         = StIdle;
          done_d          = 1'b1;
          svc_clr[chan_q] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A new edge re-arms the bit even if it is cleared in the same cycle.
  assign pend_d = (pend_q & ~(iClrPend | svc_clr)) | rise;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= StIdle;
      irq_q   <= '0;
      pend_q  <= '0;
      chan_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= iIrq;
      pend_q  <= pend_d;
      chan_q  <= chan_d;
      done_q  <= done_d;
    end
  end

  // Modulo ADDR_W arithmetic; no range check on the vector table.
  assign chan_x2  = ADDR_W'(chan_q) << 1;
  assign vec_addr = (state_q == StHi) ? (VEC_TOP - chan_x2)
                                      : (VEC_TOP - chan_x2 - ADDR_W'(1));
  assign drive    = ((state_q == StLo) || (state_q == StHi)) && iEn;

  assign oMAR    = drive ? vec_addr : {ADDR_W{1'bz}};
  assign oIntReq = (state_q == StReq);
  assign oHiByte = (state_q == StHi);
  assign oChan   = chan_q;
  assign oPend   = pend_q;
  assign oDone   = done_q;

endmodule

// File: tb/tb_irq_vector_unit.sv
// Testbench for irq_vector_unit: directed scenarios followed by randomized traffic,
// checked cycle by cycle against a behavioural model and, per completed vector fetch,
// against a scoreboard of expected service transactions.
// The MAR bus carries weak pull-downs, so an undriven bus reads as all zeros.

module tb_irq_vector_unit;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned NUM_CH = 4;
  localparam logic [15:0] VEC_TOP = 16'hFFFF;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic [3:0] irq = '0, mask = '0, clrp = '0;
  logic       inten = 1'b0, ack = 1'b0, nxt = 1'b0, en = 1'b0;
  logic       oIntReq, oHiByte, oDone;
  logic [1:0] oChan;
  logic [3:0] oPend;
  wire [15:0] mar;

  for (genvar g = 0; g < 16; g++) begin : g_pd
    pulldown (mar[g]);
  end

  irq_vector_unit #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .VEC_TOP(VEC_TOP)) dut (
    .iClk(iClk), .iRst(iRst), .iIrq(irq), .iMask(mask), .iIntEn(inten),
    .iClrPend(clrp), .iAck(ack), .iNext(nxt), .iEn(en),
    .oIntReq(oIntReq), .oChan(oChan), .oPend(oPend), .oHiByte(oHiByte),
    .oDone(oDone), .oMAR(mar)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [1:0]  chan;
    logic [15:0] lo;
    logic [15:0] hi;
  } svc_t;

  svc_t sb[$];

  // Phases of a service as the controller sees them.
  localparam int PhIdle = 0, PhReq = 1, PhLo = 2, PhHi = 3;

  int         m_phase;
  logic [3:0] m_pend, m_prev;
  logic [1:0] m_chan;
  logic       m_done;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    logic [1:0] r;
    logic found;
    r = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && !found) begin
        r = 2'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] lo_addr(input logic [1:0] k);
    return 16'(VEC_TOP - 2 * k - 1);
  endfunction

  function automatic logic [15:0] hi_addr(input logic [1:0] k);
    return 16'(VEC_TOP - 2 * k);
  endfunction

  always @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      m_phase <= PhIdle;
      m_pend  <= '0;
      m_prev  <= '0;
      m_chan  <= '0;
      m_done  <= 1'b0;
      sb.delete();
    end else begin
      logic [3:0] eligible;
      logic [3:0] serviced;
      eligible = m_pend & ~mask;
      serviced = '0;
      m_done  <= 1'b0;
      m_prev  <= irq;
      case (m_phase)
        PhIdle: if (inten && eligible != 0) m_phase <= PhReq;
        PhReq: begin
          if (ack) begin
            m_chan  <= lowest(eligible);
            m_phase <= PhLo;
            sb.push_back('{chan: lowest(eligible), lo: lo_addr(lowest(eligible)),
                           hi: hi_addr(lowest(eligible))});
          end else if (!inten || eligible == 0) begin
            m_phase <= PhIdle;
          end
        end
        PhLo: if (nxt) m_phase <= PhHi;
        default: begin
          if (nxt) begin
            m_phase <= PhIdle;
            m_done  <= 1'b1;
            serviced[m_chan] = 1'b1;
          end
        end
      endcase
      m_pend <= (m_pend & ~(clrp | serviced)) | (irq & ~m_prev);
    end
  end

  // ---------------- per-cycle checker and scoreboard monitor ----------------
  logic [15:0] lo_seen, hi_seen;
  logic        lo_ok, hi_ok;

  always @(negedge iClk or posedge iRst) begin
    if (iRst) begin
      lo_ok = 1'b0;
      hi_ok = 1'b0;
    end
    if (!iRst || !iClk) begin
      logic [15:0] exp_mar;
      exp_mar = 16'h0000;
      if (m_phase == PhLo && en) exp_mar = lo_addr(m_chan);
      if (m_phase == PhHi && en) exp_mar = hi_addr(m_chan);
      check("cyc_intreq", 32'(oIntReq), 32'(m_phase == PhReq));
      check("cyc_hibyte", 32'(oHiByte), 32'(m_phase == PhHi));
      check("cyc_done", 32'(oDone), 32'(m_done));
      check("cyc_pend", 32'(oPend), 32'(m_pend));
      check("cyc_chan", 32'(oChan), 32'(m_chan));
      check("cyc_mar", 32'(mar), 32'(exp_mar));
      if (mar != 16'h0000 && !oHiByte) begin lo_seen = mar; lo_ok = 1'b1; end
      if (mar != 16'h0000 && oHiByte)  begin hi_seen = mar; hi_ok = 1'b1; end
      if (oDone) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          svc_t e;
          e = sb.pop_front();
          check("sb_chan", 32'(oChan), 32'(e.chan));
          if (lo_ok) check("sb_lo", 32'(lo_seen), 32'(e.lo));
          if (hi_ok) check("sb_hi", 32'(hi_seen), 32'(e.hi));
        end
        lo_ok = 1'b0;
        hi_ok = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    // Reset state with no stimulus
    check("rst_mar_z", 32'(mar), 32'h0);
    check("rst_intreq", 32'(oIntReq), 32'h0);
    check("rst_pend", 32'(oPend), 32'h0);
    check("rst_done", 32'(oDone), 32'h0);
    iRst = 1'b0;
    tick();

    // Channel 0, legacy vectors
    inten = 1'b1; en = 1'b1; irq = 4'b0001;
    tick();
    check("c0_pend", 32'(oPend), 32'h1);
    check("c0_noreq_yet", 32'(oIntReq), 32'h0);
    tick();
    check("c0_req", 32'(oIntReq), 32'h1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("c0_lo", 32'(mar), 32'hFFFE);
    check("c0_lo_reqoff", 32'(oIntReq), 32'h0);
    nxt = 1'b1; tick();
    check("c0_hi", 32'(mar), 32'hFFFF);
    check("c0_hibyte", 32'(oHiByte), 32'h1);
    tick(); nxt = 1'b0;
    check("c0_done", 32'(oDone), 32'h1);
    check("c0_pend_clr", 32'(oPend), 32'h0);
    check("c0_mar_z", 32'(mar), 32'h0);
    tick();
    check("c0_done_pulse", 32'(oDone), 32'h0);

    // Simultaneous ch1/ch2 edges, ch1 masked
    irq = 4'b0110; mask = 4'b0010;
    tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    check("c2_chan", 32'(oChan), 32'h2);
    check("c2_lo", 32'(mar), 32'hFFFA);
    nxt = 1'b1; tick();
    check("c2_hi", 32'(mar), 32'hFFFB);
    tick(); nxt = 1'b0;
    check("c2_pend_left", 32'(oPend), 32'h2);
    tick();
    check("c1_masked_noreq", 32'(oIntReq), 32'h0);
    mask = 4'b0000; tick();
    check("c1_req", 32'(oIntReq), 32'h1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("c1_chan", 32'(oChan), 32'h1);
    check("c1_lo", 32'(mar), 32'hFFFC);
    nxt = 1'b1; tick();
    check("c1_hi", 32'(mar), 32'hFFFD);
    tick(); nxt = 1'b0;
    check("c1_pend_clr", 32'(oPend), 32'h0);

    // Withdrawal in REQ, then re-request
    irq = 4'b0000; tick();
    irq = 4'b0001; tick(); tick();
    check("wd_req", 32'(oIntReq), 32'h1);
    inten = 1'b0; tick();
    check("wd_withdrawn", 32'(oIntReq), 32'h0);
    check("wd_pend_kept", 32'(oPend), 32'h1);
    inten = 1'b1; tick();
    check("wd_rereq", 32'(oIntReq), 32'h1);

    // Bus enable gating during LO
    en = 1'b0; ack = 1'b1; tick(); ack = 1'b0;
    check("en_off_z", 32'(mar), 32'h0);
    en = 1'b1; #1;
    check("en_on_lo", 32'(mar), 32'hFFFE);
    tick();
    check("en_still_lo", 32'(oHiByte), 32'h0);
    nxt = 1'b1; tick(); nxt = 1'b0;
    check("en_hi", 32'(mar), 32'hFFFF);

    // New ch0 edge coinciding with the final advance
    irq = 4'b0000; tick();
    irq = 4'b0001; nxt = 1'b1; tick(); nxt = 1'b0;
    check("re_done", 32'(oDone), 32'h1);
    check("re_pend_kept", 32'(oPend), 32'h1);
    tick();
    check("re_req", 32'(oIntReq), 32'h1);
    ack = 1'b1; tick(); ack = 1'b0;
    nxt = 1'b1; tick(); tick(); nxt = 1'b0;
    check("re_pend_clr", 32'(oPend), 32'h0);

    // Software clear
    mask = 4'b1000; irq = 4'b1001; tick();
    check("sw_pend3", 32'(oPend), 32'h8);
    clrp = 4'b1000; tick(); clrp = 4'b0000;
    check("sw_clr3", 32'(oPend), 32'h0);
    mask = 4'b0000;

    // Reset asserted while presenting the high byte
    irq = 4'b1011; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    nxt = 1'b1; tick(); nxt = 1'b0;
    check("rh_hi", 32'(mar), 32'hFFFD);
    #2 iRst = 1'b1;
    #1;
    check("rh_mar_z", 32'(mar), 32'h0);
    check("rh_hibyte", 32'(oHiByte), 32'h0);
    check("rh_pend", 32'(oPend), 32'h0);
    check("rh_chan", 32'(oChan), 32'h0);
    tick(); iRst = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) irq[b] = ~irq[b];
      end
      clrp  = ($urandom_range(15) == 0) ? 4'(1 << $urandom_range(3)) : 4'b0000;
      if ($urandom_range(31) == 0) mask = 4'($urandom_range(15));
      inten = ($urandom_range(9) != 0);
      ack   = $urandom_range(1) == 1;
      nxt   = $urandom_range(2) != 0;
      en    = $urandom_range(5) != 0;
      tick();
    end

    // Drain any sequence in flight
    clrp = '0; ack = 1'b0; inten = 1'b0; nxt = 1'b1; en = 1'b1;
    repeat (6) tick();
    nxt = 1'b0;
    tick();
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
